lsu_mem_ctrl: RTL

Load/store access controller between the execute stage and the 64-bit DPI-C backed memory port. It accepts one load or store request at a time over a valid/ready handshake and aligns the address to an 8-byte word. It drives one read-enable or write-enable cycle with byte mask toward memory, extracts and sign- or zero-extends load data, and returns a single response per request. Misaligned accesses are rejected with an error response and never reach memory.

---
 rtl/lsu_mem_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store access controller sitting between the execute stage and a 64-bit
// memory port. One request is in flight at a time: it is accepted over a
// valid/ready handshake, checked for natural alignment, turned into a single
// read or write strobe toward memory, and answered with exactly one response.
// Misaligned requests never touch memory and come back with resp_err set.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_store             : 1 = store, 0 = load
//   req_size              : 0 byte, 1 half, 2 word, 3 double
//   req_signed            : sign-extend load data (ignored for stores/doubles)
//   req_addr, req_wdata   : byte address, right-justified store data
//   resp_valid/resp_ready : response handshake
//   resp_rdata, resp_err  : extended load data (0 for stores/errors), error flag
//   mem_rd_en/addr/data   : read strobe, aligned address, combinational data in
//   mem_we_en/addr/data/mask : write strobe, aligned address, lane data, byte enables
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                mem_we_en,
    output logic [ADDR_W-1:0]   mem_we_addr,
    output logic [DATA_W-1:0]   mem_we_data,
    output logic [DATA_W/8-1:0] mem_we_mask
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ERR,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic                store_q, store_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [5:0]          lane_shift;
    logic [ADDR_W-1:0]   word_addr;
    logic                req_misaligned;
    logic [7:0]          size_mask;
    logic [DATA_W-1:0]   load_raw;
    logic [DATA_W-1:0]   load_ext;

    // Byte lane within the 8-byte word, expressed as a bit shift.
    assign lane_shift = {addr_q[2:0], 3'b000};
    assign word_addr  = {addr_q[ADDR_W-1:3], 3'b000};

    // Natural alignment check on the incoming request. An aligned access of
    // at most 8 bytes can never straddle a word, so no split is needed.
    always_comb begin
        case (req_size)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = |req_addr[2:0];
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend by size.
    always_comb begin
        load_raw = mem_rd_data >> lane_shift;
        case (size_q)
            2'd0:    load_ext = signed_q ? {{(DATA_W-8){load_raw[7]}}, load_raw[7:0]}
                                         : {{(DATA_W-8){1'b0}}, load_raw[7:0]};
            2'd1:    load_ext = signed_q ? {{(DATA_W-16){load_raw[15]}}, load_raw[15:0]}
                                         : {{(DATA_W-16){1'b0}}, load_raw[15:0]};
            2'd2:    load_ext = signed_q ? {{(DATA_W-32){load_raw[31]}}, load_raw[31:0]}
                                         : {{(DATA_W-32){1'b0}}, load_raw[31:0]};
            default: load_ext = load_raw;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        store_d     = store_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_err    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_we_en   = 1'b0;
        mem_we_addr = '0;
        mem_we_data = '0;
        mem_we_mask = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    store_d  = req_store;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    state_d  = req_misaligned ? ERR : ACC;
                end
            end
            ACC: begin
                err_d = 1'b0;
                if (store_q) begin
                    mem_we_en   = 1'b1;
                    mem_we_addr = word_addr;
                    mem_we_data = wdata_q << lane_shift;
                    mem_we_mask = size_mask << addr_q[2:0];
                    rdata_d     = '0;
                end else begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = word_addr;
                    rdata_d     = load_ext;
                end
                state_d = RESP;
            end
            ERR: begin
                err_d   = 1'b1;
                rdata_d = '0;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before the edge, independent of statement order.
            state_q  <= state_d;
            store_q  <= store_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
